multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
// Main sequencer for the multi-cycle variant of the core. It steps each instruction
// through fetch, decode, execute, memory and writeback, and drives the datapath muxes
// and write enables. It also produces the 3-bit ALUOp consumed by ALU_control_unit.
// The shared ALU and the unified memory port are time-multiplexed across the states.
// PARAMETERS
// ALUOP_WIDTH    3    width of ALUOp; codes: 0 RI, 1 JALR, 2 S, 3 SB, 4 U, 5 UJ
// PORTS
// clk            in   1   system clock, rising edge
// rst            in   1   asynchronous, active-high reset
// opcode         in   7   instr[6:0] from instruction register (valid DECODE onward)
// mem_ready      in   1   memory completes the access in this cycle
// pc_write       out  1   load PC (fetch PC+4, jump/JALR target)
// branch_en      out  1   load PC from ALUOut if ALU zero/compare flag set
// ir_write       out  1   latch fetched word into IR and old-PC register
// reg_write      out  1   register file write enable
// mem_req        out  1   memory access request
// mem_we         out  1   write qualifier for mem_req
// adr_src        out  1   memory address: 0 PC, 1 ALUOut
// alu_src_a      out  2   0 PC, 1 old PC, 2 rs1
// alu_src_b      out  2   0 rs2, 1 imm, 2 const 4
// result_src     out  2   writeback: 0 ALUOut, 1 mem data, 2 ALU result
// ALUOp          out  3   class code to ALU_control_unit
// illegal_instr  out  1   one-cycle pulse on unknown opcode
// BEHAVIOUR
// - States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB,
//   BRANCH, JAL, JALR, LUI, AUIPC. 4-bit state register.
// - Reset: state=FETCH. While rst=1, every output is 0 (ALUOp=0).
// - FETCH: mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, ALUOp=0/ADD path via
//   U code (4). Stay in FETCH while mem_ready=0.
//   When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle (Mealy), then go to DECODE.
// - DECODE (1 cycle): alu_src_a=1, alu_src_b=1, ALUOp=5, computes old PC+imm into ALUOut.
//   Next state by opcode:
//     0000011/0100011 -> MEM_ADR;  0110011 -> EXEC_R;  0010011 -> EXEC_I
//     1100011 -> BRANCH;  1101111 -> JAL;  1100111 -> JALR
//     0110111 -> LUI;  0010111 -> AUIPC
//     other -> FETCH with illegal_instr=1 and no write enables
// - MEM_ADR: a=2, b=1, ALUOp=2 (ADD for every load width). Next: MEM_RD if opcode[5]=0,
//   else MEM_WR.
// - MEM_RD: mem_req=1, adr_src=1; wait on mem_ready, then MEM_WB.
// - MEM_WB: reg_write=1, result_src=1 -> FETCH.
// - MEM_WR: mem_req=1, mem_we=1, adr_src=1; wait on mem_ready, then FETCH.
// - EXEC_R: a=2, b=0, ALUOp=0 -> ALU_WB.  EXEC_I: a=2, b=1, ALUOp=0 -> ALU_WB.
// - ALU_WB: reg_write=1, result_src=0 -> FETCH.
// - BRANCH: a=2, b=0, ALUOp=3, branch_en=1, result_src=0 -> FETCH.
// - JAL: a=1, b=2, ALUOp=5, reg_write=1 (rd=PC+4), result_src=2.
//   Also pc_write=1 from ALUOut -> FETCH.
// - JALR: a=2, b=1, ALUOp=1, pc_write=1 from ALU result (result_src=2) -> ALU_WB-like
//   rd write of old PC+4 in the following JAL-style cycle, then FETCH.
// - LUI: a=0 (zero gated by datapath), b=1, ALUOp=4 -> ALU_WB.
//   AUIPC: a=1, b=1, ALUOp=4 -> ALU_WB.
// - Outputs not listed for a state are 0. mem_req stays high until the mem_ready cycle.
// - Async rst in any state (including mid memory wait) returns to FETCH immediately,
//   with outputs 0; mem_req drops the same cycle.
// - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
// TESTING
// - Reset mid-MEM_RD: assert rst, check mem_req=0 at once. Release rst, check FETCH
//   with mem_req=1 on the next edge.
// - R-type add, mem_ready=1 immediately: FETCH->DECODE->EXEC_R->ALU_WB.
//   Exactly 4 cycles, one reg_write pulse, ALUOp=0 in EXEC_R.
// - lw, mem_ready delayed 3 cycles in FETCH and 2 cycles in MEM_RD:
//   total 5+3+2=10 cycles, ir_write exactly once.
// - sw: MEM_WR shows mem_we=1, adr_src=1, and no reg_write in any state.
// - beq: BRANCH cycle shows ALUOp=3 and branch_en=1, with pc_write=0 outside FETCH.
// - opcode 7'b1111111: illegal_instr pulses once at DECODE, and the FSM returns to FETCH
//   with no write enable.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle core sequencer: walks each instruction through fetch/decode/execute/
// memory/writeback and drives datapath mux selects, write enables and ALUOp.
module multicycle_control_fsm #(
   parameter int ALUOP_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [6:0]             opcode,
   input  logic                   mem_ready,
   output logic                   pc_write,
   output logic                   branch_en,
   output logic                   ir_write,
   output logic                   reg_write,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic                   adr_src,
   output logic [1:0]             alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [1:0]             result_src,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic                   illegal_instr
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEM_ADR = 4'd2;
   localparam logic [3:0] S_MEM_RD  = 4'd3;
   localparam logic [3:0] S_MEM_WB  = 4'd4;
   localparam logic [3:0] S_MEM_WR  = 4'd5;
   localparam logic [3:0] S_EXEC_R  = 4'd6;
   localparam logic [3:0] S_EXEC_I  = 4'd7;
   localparam logic [3:0] S_ALU_WB  = 4'd8;
   localparam logic [3:0] S_BRANCH  = 4'd9;
   localparam logic [3:0] S_JAL     = 4'd10;
   localparam logic [3:0] S_JALR    = 4'd11;
   localparam logic [3:0] S_LUI     = 4'd12;
   localparam logic [3:0] S_AUIPC   = 4'd13;
   localparam logic [3:0] S_JALR_WB = 4'd14;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [ALUOP_WIDTH-1:0] ALU_RI   = ALUOP_WIDTH'(0);
   localparam logic [ALUOP_WIDTH-1:0] ALU_JALR = ALUOP_WIDTH'(1);
   localparam logic [ALUOP_WIDTH-1:0] ALU_S    = ALUOP_WIDTH'(2);
   localparam logic [ALUOP_WIDTH-1:0] ALU_SB   = ALUOP_WIDTH'(3);
   localparam logic [ALUOP_WIDTH-1:0] ALU_U    = ALUOP_WIDTH'(4);
   localparam logic [ALUOP_WIDTH-1:0] ALU_UJ   = ALUOP_WIDTH'(5);

   logic [3:0] state_q, state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      branch_en     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      result_src    = 2'd0;
      ALUOp         = ALU_RI;
      illegal_instr = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC+4 goes through the U-class (plain ADD) path
            mem_req   = 1'b1;
            alu_src_b = 2'd2;
            ALUOp     = ALU_U;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            ALUOp     = ALU_UJ;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default: begin
                  illegal_instr = 1'b1;
                  state_d       = S_FETCH;
               end
            endcase
         end
         S_MEM_ADR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            ALUOp     = ALU_S;
            state_d   = opcode[5] ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_src = 2'd1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = 2'd2;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 2'd2;
            ALUOp     = ALU_SB;
            branch_en = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = 2'd1;
            alu_src_b  = 2'd2;
            ALUOp      = ALU_UJ;
            reg_write  = 1'b1;
            result_src = 2'd2;
            pc_write   = 1'b1;
            state_d    = S_FETCH;
         end
         S_JALR: begin
            alu_src_a  = 2'd2;
            alu_src_b  = 2'd1;
            ALUOp      = ALU_JALR;
            pc_write   = 1'b1;
            result_src = 2'd2;
            state_d    = S_JALR_WB;
         end
         S_JALR_WB: begin
            // link write of old PC+4, after the PC has already been redirected
            alu_src_a  = 2'd1;
            alu_src_b  = 2'd2;
            ALUOp      = ALU_UJ;
            reg_write  = 1'b1;
            result_src = 2'd2;
            state_d    = S_FETCH;
         end
         S_LUI: begin
            alu_src_b = 2'd1;
            ALUOp     = ALU_U;
            state_d   = S_ALU_WB;
         end
         S_AUIPC: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            ALUOp     = ALU_U;
            state_d   = S_ALU_WB;
         end
         default: state_d = S_FETCH;
      endcase
      // outputs are forced quiet for the whole reset assertion, not just after the edge
      if (rst) begin
         pc_write      = 1'b0;
         branch_en     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         adr_src       = 1'b0;
         alu_src_a     = 2'd0;
         alu_src_b     = 2'd0;
         result_src    = 2'd0;
         ALUOp         = ALU_RI;
         illegal_instr = 1'b0;
      end
   end

endmodule
